// File: rtl/freq_counter.sv
// rtl/freq_counter.sv - symbol frequency table builder over a shared SRAM port
//
// Ports:
//   clk, rst      single clock, synchronous active-high reset
//   freq_enable   level; this stage owns the SRAM port while high
//   sym_valid     incoming symbol byte valid
//   sym_in        incoming symbol byte
//   EOT_flag      end-of-text marker from the byte source
//   sram_rdata    SRAM read data, valid RD_LAT cycles after the read strobe
//   sym_ready     symbol accepted this cycle when sym_valid is also high
//   sym_addr      SRAM word address
//   sym_read      SRAM read strobe
//   sym_write     SRAM write strobe
//   sym_data      SRAM write data
//   freq_done     one-cycle pulse when the table is complete

module freq_counter #(
  parameter logic [15:0] BASE_ADDR = 16'h0100,
  parameter int          RD_LAT    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freq_enable,
  input  logic        sym_valid,
  input  logic [7:0]  sym_in,
  input  logic        EOT_flag,
  input  logic [7:0]  sram_rdata,
  output logic        sym_ready,
  output logic [15:0] sym_addr,
  output logic        sym_read,
  output logic        sym_write,
  output logic [7:0]  sym_data,
  output logic        freq_done
);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    WAIT_SYM,
    READ,
    WAIT_RD,
    WRITE,
    DONE
  } state_t;

  localparam logic [1:0] RD_LAST = 2'(RD_LAT - 1);

  state_t      state_q;
  logic [7:0]  idx_q;
  logic [1:0]  cnt_q;
  logic [7:0]  sym_q;
  logic        eot_q;
  logic        armed_q;   // freq_enable has been seen low since the last run
  logic        ready_q;
  logic [15:0] addr_q;
  logic        read_q;
  logic        write_q;
  logic [7:0]  data_q;
  logic        done_q;

  logic [7:0]  idx_d;
  logic [7:0]  sat_d;
  logic        eot_d;
  logic        busy;

  assign idx_d = idx_q + 8'd1;
  // Counts saturate so a very frequent symbol never wraps back to zero.
  assign sat_d = (sram_rdata == 8'hFF) ? 8'hFF : sram_rdata + 8'd1;
  assign eot_d = eot_q | EOT_flag;
  // States that a dropped freq_enable aborts.
  assign busy  = (state_q == CLEAR) || (state_q == WAIT_SYM) || (state_q == READ) ||
                 (state_q == WAIT_RD) || (state_q == WRITE);

  // Outputs are registered: each branch sets the values that belong to the
  // state being entered, so they are valid for the whole of that state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 8'h00;
      cnt_q   <= 2'd0;
      sym_q   <= 8'h00;
      eot_q   <= 1'b0;
      armed_q <= 1'b0;
      ready_q <= 1'b0;
      addr_q  <= 16'h0000;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      data_q  <= 8'h00;
      done_q  <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      addr_q  <= 16'h0000;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      data_q  <= 8'h00;
      done_q  <= 1'b0;

      if (busy && !freq_enable) begin
        // Abort: the SRAM port is no longer ours; a half-done entry is left.
        state_q <= IDLE;
        eot_q   <= 1'b0;
        armed_q <= 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
            if (!freq_enable) begin
              armed_q <= 1'b1;
            end else if (armed_q) begin
              state_q <= CLEAR;
              armed_q <= 1'b0;
              idx_q   <= 8'h00;
              write_q <= 1'b1;
              addr_q  <= BASE_ADDR;
            end
          end

          CLEAR: begin
            eot_q <= eot_d;
            if (idx_q == 8'hFF) begin
              if (eot_d) begin
                state_q <= DONE;
                done_q  <= 1'b1;
              end else begin
                state_q <= WAIT_SYM;
                ready_q <= 1'b1;
              end
            end else begin
              idx_q   <= idx_d;
              write_q <= 1'b1;
              addr_q  <= BASE_ADDR + {8'h00, idx_d};
            end
          end

          WAIT_SYM: begin
            if (sym_valid) begin
              state_q <= READ;
              sym_q   <= sym_in;
              eot_q   <= EOT_flag;
              read_q  <= 1'b1;
              addr_q  <= BASE_ADDR + {8'h00, sym_in};
            end else if (EOT_flag) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              ready_q <= 1'b1;
            end
          end

          READ: begin
            eot_q   <= eot_d;
            state_q <= WAIT_RD;
            cnt_q   <= 2'd0;
            addr_q  <= addr_q;
          end

          WAIT_RD: begin
            eot_q <= eot_d;
            if (cnt_q == RD_LAST) begin
              state_q <= WRITE;
              write_q <= 1'b1;
              addr_q  <= BASE_ADDR + {8'h00, sym_q};
              data_q  <= sat_d;
            end else begin
              cnt_q  <= cnt_q + 2'd1;
              addr_q <= addr_q;
            end
          end

          WRITE: begin
            if (eot_d) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= WAIT_SYM;
              ready_q <= 1'b1;
            end
          end

          DONE: begin
            state_q <= IDLE;
            eot_q   <= 1'b0;
            armed_q <= !freq_enable;
          end

          default: begin
            state_q <= IDLE;
            eot_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign sym_ready = ready_q;
  assign sym_addr  = addr_q;
  assign sym_read  = read_q;
  assign sym_write = write_q;
  assign sym_data  = data_q;
  assign freq_done = done_q;

endmodule

// File: tb/tb_freq_counter.sv
// tb/tb_freq_counter.sv - directed self-checking bench for freq_counter

module tb_freq_counter;

  logic        clk = 1'b0;
  logic        rst;
  logic        freq_enable;
  logic        sym_valid;
  logic [7:0]  sym_in;
  logic        EOT_flag;
  logic [7:0]  rdata;
  logic        ready, rd, wr, done;
  logic [15:0] addr;
  logic [7:0]  wdata;

  logic        w_en;
  logic [7:0]  w_rdata;
  logic        w_ready, w_rd, w_wr, w_done;
  logic [15:0] w_addr;
  logic [7:0]  w_wdata;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  freq_counter u_dut (
    .clk(clk), .rst(rst), .freq_enable(freq_enable), .sym_valid(sym_valid),
    .sym_in(sym_in), .EOT_flag(EOT_flag), .sram_rdata(rdata),
    .sym_ready(ready), .sym_addr(addr), .sym_read(rd), .sym_write(wr),
    .sym_data(wdata), .freq_done(done)
  );

  freq_counter #(.BASE_ADDR(16'hFF80), .RD_LAT(2)) u_wrap (
    .clk(clk), .rst(rst), .freq_enable(w_en), .sym_valid(sym_valid),
    .sym_in(sym_in), .EOT_flag(EOT_flag), .sram_rdata(w_rdata),
    .sym_ready(w_ready), .sym_addr(w_addr), .sym_read(w_rd), .sym_write(w_wr),
    .sym_data(w_wdata), .freq_done(w_done)
  );

  // SRAM models and event counters (outputs sampled at posedge = prior cycle)
  logic [7:0]  mem  [0:65535];
  logic [7:0]  wmem [0:65535];
  logic        mem_init = 1'b0;
  logic        pre_en = 1'b0;
  logic [15:0] pre_addr = 16'h0000;
  logic [7:0]  pre_val = 8'h00;
  logic [7:0]  w_p1;
  int wr_cnt = 0, done_cnt = 0, viol = 0, w_wr_cnt = 0;
  logic [15:0] w_last = 16'h0000;

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 65536; i++) begin
        mem[i]  = 8'hAA;
        wmem[i] = 8'hAA;
      end
      mem_init = 1'b1;
    end
    if (pre_en) mem[pre_addr] = pre_val;
    if (wr) begin
      mem[addr] = wdata;
      wr_cnt++;
    end
    rdata <= mem[addr];
    if (done) done_cnt++;
    if (rd && wr) viol++;
  end

  always @(posedge clk) begin
    if (w_wr) begin
      wmem[w_addr] = w_wdata;
      w_wr_cnt++;
      w_last = w_addr;
    end
    w_p1    <= wmem[w_addr];
    w_rdata <= w_p1;
    if (w_rd && w_wr) viol++;
  end

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic present_sym(input logic [7:0] s, input logic e);
    int k = 0;
    while (!ready && k < 400) begin
      tick();
      k++;
    end
    n_cmp++;
    if (!ready) begin
      n_bad++;
      $display("FAIL ready_timeout: sym_ready=%b required 1", ready);
    end
    sym_valid = 1'b1;
    sym_in    = s;
    EOT_flag  = e;
    tick();
    sym_valid = 1'b0;
    EOT_flag  = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; freq_enable = 1'b0; w_en = 1'b0;
    sym_valid = 1'b0; sym_in = 8'h00; EOT_flag = 1'b0;
    tick(); tick();
    n_cmp++;
    if ({ready, addr, rd, wr, wdata, done} !== 28'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h required 0", {ready, addr, rd, wr, wdata, done});
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if ({ready, wr} !== 2'b00) begin
      n_bad++;
      $display("FAIL idle_quiet: ready/write=%b required 00", {ready, wr});
    end
  endtask

  task automatic test_clear;
    int n = 0;
    int bad_addr = 0;
    int nz = 0;
    freq_enable = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (ready) break;
      if (wr) begin
        if (addr !== 16'h0100 + 16'(n) || wdata !== 8'h00 || rd !== 1'b0) bad_addr++;
        n++;
      end
    end
    n_cmp++;
    if (n != 256) begin
      n_bad++;
      $display("FAIL clear_count: got %0d writes required 256", n);
    end
    n_cmp++;
    if (bad_addr != 0) begin
      n_bad++;
      $display("FAIL clear_addr_data: %0d bad write cycles required 0", bad_addr);
    end
    n_cmp++;
    if (ready !== 1'b1) begin
      n_bad++;
      $display("FAIL clear_ready: sym_ready=%b required 1", ready);
    end
    for (int a = 16'h0100; a <= 16'h01FF; a++) if (mem[a] !== 8'h00) nz++;
    n_cmp++;
    if (nz != 0) begin
      n_bad++;
      $display("FAIL clear_mem: %0d nonzero entries required 0", nz);
    end
  endtask

  task automatic test_count;
    logic [7:0] syms [3] = '{8'h41, 8'h41, 8'h42};
    logic [7:0] exp  [3] = '{8'h01, 8'h02, 8'h01};
    for (int i = 0; i < 3; i++) begin
      present_sym(syms[i], 1'b0);
      n_cmp++;
      if (rd !== 1'b1 || wr !== 1'b0 || addr !== 16'h0100 + {8'h00, syms[i]}) begin
        n_bad++;
        $display("FAIL count_read%0d: rd=%b wr=%b addr=%h required 1 0 %h",
                 i, rd, wr, addr, 16'h0100 + {8'h00, syms[i]});
      end
      sym_valid = 1'b1; sym_in = 8'h55;   // must be ignored while busy
      tick();
      n_cmp++;
      if (rd !== 1'b0 || wr !== 1'b0 || ready !== 1'b0 || addr !== 16'h0100 + {8'h00, syms[i]}) begin
        n_bad++;
        $display("FAIL count_waitrd%0d: rd=%b wr=%b ready=%b addr=%h", i, rd, wr, ready, addr);
      end
      tick();
      sym_valid = 1'b0;
      n_cmp++;
      if (wr !== 1'b1 || rd !== 1'b0 || addr !== 16'h0100 + {8'h00, syms[i]} || wdata !== exp[i]) begin
        n_bad++;
        $display("FAIL count_write%0d: wr=%b addr=%h data=%h required 1 %h %h",
                 i, wr, addr, wdata, 16'h0100 + {8'h00, syms[i]}, exp[i]);
      end
    end
    tick();
    n_cmp++;
    if (mem[16'h0141] !== 8'h02 || mem[16'h0142] !== 8'h01 || mem[16'h0155] !== 8'h00) begin
      n_bad++;
      $display("FAIL count_mem: 141=%h 142=%h 155=%h required 02 01 00",
               mem[16'h0141], mem[16'h0142], mem[16'h0155]);
    end
  endtask

  task automatic test_saturation;
    pre_en = 1'b1; pre_addr = 16'h01FF; pre_val = 8'hFF;
    tick();
    pre_en = 1'b0;
    present_sym(8'hFF, 1'b0);
    tick(); tick();
    n_cmp++;
    if (wr !== 1'b1 || addr !== 16'h01FF || wdata !== 8'hFF) begin
      n_bad++;
      $display("FAIL saturate: wr=%b addr=%h data=%h required 1 01ff ff", wr, addr, wdata);
    end
  endtask

  task automatic test_simultaneous;
    int w0;
    present_sym(8'h10, 1'b1);
    tick(); tick();
    n_cmp++;
    if (wr !== 1'b1 || addr !== 16'h0110 || wdata !== 8'h01 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL simul_write: wr=%b addr=%h data=%h done=%b required 1 0110 01 0", wr, addr, wdata, done);
    end
    tick();
    n_cmp++;
    if (done !== 1'b1 || wr !== 1'b0) begin
      n_bad++;
      $display("FAIL simul_done: done=%b wr=%b required 1 0", done, wr);
    end
    tick();
    n_cmp++;
    if (done !== 1'b0 || ready !== 1'b0 || mem[16'h0110] !== 8'h01) begin
      n_bad++;
      $display("FAIL simul_after: done=%b ready=%b mem=%h required 0 0 01", done, ready, mem[16'h0110]);
    end
    w0 = wr_cnt;
    for (int i = 0; i < 5; i++) tick();
    n_cmp++;
    if (wr_cnt != w0) begin
      n_bad++;
      $display("FAIL no_reclear: %0d writes required 0", wr_cnt - w0);
    end
  endtask

  task automatic test_eot_idle;
    freq_enable = 1'b0;
    tick();
    freq_enable = 1'b1;
    for (int i = 0; i < 300 && !ready; i++) tick();
    EOT_flag = 1'b1;
    tick();
    EOT_flag = 1'b0;
    n_cmp++;
    if (done !== 1'b1 || wr !== 1'b0 || rd !== 1'b0) begin
      n_bad++;
      $display("FAIL eot_idle_done: done=%b wr=%b rd=%b required 1 0 0", done, wr, rd);
    end
    tick();
    n_cmp++;
    if (done !== 1'b0) begin
      n_bad++;
      $display("FAIL eot_idle_pulse: done=%b required 0", done);
    end
  endtask

  task automatic test_abort;
    int wc, dc;
    freq_enable = 1'b0;
    tick();
    freq_enable = 1'b1;
    tick();
    present_sym(8'h20, 1'b0);
    tick();
    freq_enable = 1'b0;
    wc = wr_cnt; dc = done_cnt;
    tick();
    n_cmp++;
    if ({ready, addr, rd, wr, wdata, done} !== 28'h0) begin
      n_bad++;
      $display("FAIL abort_outputs: got %h required 0", {ready, addr, rd, wr, wdata, done});
    end
    for (int i = 0; i < 4; i++) tick();
    n_cmp++;
    if (wr_cnt != wc || done_cnt != dc || mem[16'h0120] !== 8'h00) begin
      n_bad++;
      $display("FAIL abort_quiet: writes=%0d dones=%0d mem=%h required 0 0 00",
               wr_cnt - wc, done_cnt - dc, mem[16'h0120]);
    end
  endtask

  task automatic test_rst_clear;
    int wc;
    freq_enable = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    n_cmp++;
    if (wr !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_in_clear_pre: wr=%b required 1", wr);
    end
    rst = 1'b1;
    tick();
    n_cmp++;
    if ({ready, addr, rd, wr, wdata, done} !== 28'h0) begin
      n_bad++;
      $display("FAIL rst_in_clear: got %h required 0", {ready, addr, rd, wr, wdata, done});
    end
    rst = 1'b0;
    wc = wr_cnt;
    for (int i = 0; i < 3; i++) tick();
    n_cmp++;
    if (wr_cnt != wc) begin
      n_bad++;
      $display("FAIL rst_rearm: %0d writes required 0", wr_cnt - wc);
    end
    freq_enable = 1'b0;
    tick();
  endtask

  task automatic test_wrap;
    w_en = 1'b1;
    for (int i = 0; i < 300 && !w_ready; i++) tick();
    n_cmp++;
    if (w_wr_cnt != 256 || w_last !== 16'h007F || w_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL wrap_clear: writes=%0d last=%h ready=%b required 256 007f 1", w_wr_cnt, w_last, w_ready);
    end
    sym_valid = 1'b1; sym_in = 8'hFF;
    tick();
    sym_valid = 1'b0;
    n_cmp++;
    if (w_rd !== 1'b1 || w_addr !== 16'h007F) begin
      n_bad++;
      $display("FAIL wrap_read: rd=%b addr=%h required 1 007f", w_rd, w_addr);
    end
    tick(); tick();
    n_cmp++;
    if (w_wr !== 1'b0 || w_addr !== 16'h007F) begin
      n_bad++;
      $display("FAIL wrap_lat2: wr=%b addr=%h required 0 007f", w_wr, w_addr);
    end
    tick();
    n_cmp++;
    if (w_wr !== 1'b1 || w_addr !== 16'h007F || w_wdata !== 8'h01) begin
      n_bad++;
      $display("FAIL wrap_write: wr=%b addr=%h data=%h required 1 007f 01", w_wr, w_addr, w_wdata);
    end
    tick();
    w_en = 1'b0;
    tick();
  endtask

  task automatic test_exclusive;
    n_cmp++;
    if (viol != 0) begin
      n_bad++;
      $display("FAIL read_write_exclusive: %0d cycles with both strobes required 0", viol);
    end
  endtask

  initial begin
    test_reset();
    test_clear();
    test_count();
    test_saturation();
    test_simultaneous();
    test_eot_idle();
    test_abort();
    test_rst_clear();
    test_wrap();
    test_exclusive();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/freq_counter.md
FREQ_COUNTER -- requirements
Module: freq_counter

Interface
REQ-001 Parameter BASE_ADDR, default 16'h0100, is the SRAM word address of frequency-table entry 0.
REQ-002 Parameter RD_LAT, default 1, range 1-4, is the number of cycles from the sym_read cycle to the cycle in which sram_rdata is valid.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 freq_enable  input  1  level; high means the frequency stage owns the SRAM port (SRAM mux state 3'b010).
REQ-006 sym_valid  input  1  incoming symbol byte is valid.
REQ-007 sym_in  input  8  incoming symbol byte.
REQ-008 EOT_flag  input  1  end-of-text marker from the byte source.
REQ-009 sram_rdata  input  8  SRAM read data.
REQ-010 sym_ready  output  1  block accepts a symbol this cycle.
REQ-011 sym_addr  output  16  SRAM address, driven to the SRAM mux.
REQ-012 sym_read  output  1  SRAM read strobe.
REQ-013 sym_write  output  1  SRAM write strobe.
REQ-014 sym_data  output  8  SRAM write data.
REQ-015 freq_done  output  1  one-cycle pulse when the table is complete.

Function
REQ-016 The block SHALL implement the FSM states IDLE, CLEAR, WAIT_SYM, READ, WAIT_RD, WRITE and DONE.
REQ-017 IDLE: when freq_enable=1, the next state SHALL be CLEAR with clear index 0.
REQ-018 CLEAR: each cycle SHALL drive sym_write=1, sym_addr=BASE_ADDR+idx, sym_data=0, then increment idx; after idx=255 the next state SHALL be WAIT_SYM, for exactly 256 write cycles.
REQ-019 WAIT_SYM: sym_ready SHALL be 1; a symbol is accepted when sym_valid&&sym_ready, its value is latched, and the next state SHALL be READ.
REQ-020 READ: SHALL drive sym_read=1 and sym_addr=BASE_ADDR+{8'h00,sym} for exactly one cycle, then enter WAIT_RD.
REQ-021 WAIT_RD: SHALL hold sym_addr and remain for RD_LAT cycles, capturing sram_rdata on the last of them.
REQ-022 WRITE: SHALL drive sym_write=1, the same sym_addr, and sym_data=captured+1 saturating at 8'hFF, for one cycle; the next state SHALL be WAIT_SYM.
REQ-023 Symbol throughput SHALL be one symbol per RD_LAT+3 cycles; with acceptance at cycle T and RD_LAT=1, READ occurs at T+1 and WRITE at T+3.
REQ-024 Address arithmetic SHALL be 16-bit modulo, so BASE_ADDR+255 wraps past 16'hFFFF.
REQ-025 sym_read and sym_write SHALL never both be 1; in all states other than CLEAR, READ, WAIT_RD and WRITE, sym_addr, sym_data, sym_read and sym_write SHALL be 0.
REQ-026 EOT_flag=1 in WAIT_SYM with sym_valid=0 SHALL cause the next state to be DONE.
REQ-027 EOT_flag=1 with an accepted symbol in the same cycle, or EOT_flag=1 in CLEAR, READ, WAIT_RD or WRITE, SHALL be latched; the pending symbol SHALL complete, and WRITE (or the end of CLEAR) SHALL then go to DONE.
REQ-028 DONE: SHALL pulse freq_done=1 for one cycle and clear the EOT latch; the next state SHALL be IDLE.
REQ-029 IDLE SHALL NOT re-enter CLEAR until freq_enable has been seen low at least one cycle.
REQ-030 freq_enable=0 in any state other than IDLE or DONE SHALL abort to IDLE on the next edge, with no further strobes, no freq_done, and the EOT latch cleared; a partially written entry is not repaired.
REQ-031 sym_ready SHALL be 0 in every state except WAIT_SYM; symbols presented while sym_ready=0 SHALL be ignored, not queued.

Reset
REQ-032 rst=1 at a clock edge SHALL put the FSM in IDLE, set idx=0, clear the EOT latch and the symbol and data registers, and set every output to 0, including in the middle of any operation.
REQ-033 After rst is released, the block SHALL behave as from power-up, and REQ-029 SHALL apply.

Verification
REQ-034 Clear: rst, then freq_enable=1 -> 256 consecutive writes of 0 to addresses 16'h0100..16'h01FF, then sym_ready=1.
REQ-035 Count: symbols 8'h41, 8'h41, 8'h42 with an SRAM model (RD_LAT=1) -> final mem[16'h0141]=2 and mem[16'h0142]=1; each WRITE occurs 2 cycles after its READ.
REQ-036 Saturation: preload mem[16'h01FF]=8'hFF and send 8'hFF -> write data is 8'hFF.
REQ-037 Simultaneous: sym_valid=1 with sym_in=8'h10 and EOT_flag=1 in the same cycle -> mem[16'h0110] is incremented, then freq_done pulses one cycle after WRITE.
REQ-038 Wrap: BASE_ADDR=16'hFF80 and symbol 8'hFF -> sym_addr=16'h007F.
REQ-039 Abort and reset: freq_enable dropped during WAIT_RD -> IDLE, no write, no freq_done; rst asserted during CLEAR -> all outputs 0 on the next cycle.
